// File: rtl/netbus_packet_tx.sv
// netbus_packet_tx: packet source feeding the read side of a NetBus mux port.
// It frames a (dest, len) command and its payload words into SOP/EOP flits that carry a 4-bit sequence number.
module netbus_packet_tx #(
  parameter int DATA_WIDTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic                       CLK,
  input  logic                       RESETn,
  input  logic                       CMD_VALID,
  output logic                       CMD_READY,
  input  logic [7:0]                 CMD_DEST,
  input  logic [LEN_W-1:0]           CMD_LEN,
  input  logic [DATA_WIDTH*9-1:0]    PAY_DATA,
  input  logic                       PAY_VALID,
  output logic                       PAY_READY,
  output logic [DATA_WIDTH*9+13:0]   RDATA,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic                       BUSY,
  output logic [15:0]                PKT_CNT
);

  localparam int P  = DATA_WIDTH * 9;
  localparam int FW = P + 14;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state;
  logic [7:0]      dest;
  logic [LEN_W-1:0] rem;
  logic [3:0]      seq;
  logic            first;
  logic [FW-1:0]   rdata_q;
  logic            rvalid_q;
  logic [15:0]     pkt_cnt;

  logic            pay_hs;
  logic            out_hs;
  logic            last_word;

  // A payload word may only be taken when the single output register is free or draining this cycle.
  assign CMD_READY = (state == IDLE);
  assign PAY_READY = (state == SEND) && (!rvalid_q || RREADY);
  assign pay_hs    = PAY_VALID && PAY_READY;
  assign out_hs    = rvalid_q && RREADY;
  assign last_word = (rem == '0);

  assign RDATA   = rdata_q;
  assign RVALID  = rvalid_q;
  assign BUSY    = (state == SEND) || rvalid_q;
  assign PKT_CNT = pkt_cnt;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= IDLE;
      dest     <= '0;
      rem      <= '0;
      seq      <= '0;
      first    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      if (out_hs && rdata_q[P+4])
        pkt_cnt <= pkt_cnt + 16'd1;

      // Reload wins over drain, so a handshake and a new word in the same cycle keep RVALID high.
      if (pay_hs) begin
        rdata_q  <= {dest, first, last_word, seq, PAY_DATA};
        rvalid_q <= 1'b1;
      end else if (RREADY) begin
        rvalid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            dest  <= CMD_DEST;
            rem   <= CMD_LEN;
            seq   <= '0;
            first <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          if (pay_hs) begin
            first <= 1'b0;
            seq   <= seq + 4'd1;
            rem   <= rem - LEN_W'(1);
            if (last_word)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_netbus_packet_tx.sv
// Self-checking bench for netbus_packet_tx: a flit-queue model built from each command is compared on every cycle.
module tb_netbus_packet_tx;

  localparam int DW = 4;
  localparam int LW = 8;
  localparam int P  = DW * 9;
  localparam int FW = P + 14;
  localparam int LIMIT = 2000;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic          CMD_VALID;
  logic          CMD_READY;
  logic [7:0]    CMD_DEST;
  logic [LW-1:0] CMD_LEN;
  logic [P-1:0]  PAY_DATA;
  logic          PAY_VALID;
  logic          PAY_READY;
  logic [FW-1:0] RDATA;
  logic          RVALID;
  logic          RREADY = 1'b1;
  logic          BUSY;
  logic [15:0]   PKT_CNT;

  netbus_packet_tx #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DEST(CMD_DEST), .CMD_LEN(CMD_LEN),
    .PAY_DATA(PAY_DATA), .PAY_VALID(PAY_VALID), .PAY_READY(PAY_READY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .BUSY(BUSY), .PKT_CNT(PKT_CNT)
  );

  always #5 CLK = ~CLK;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            rreadyMode = 0;
  int            rrCnt = 0;
  logic [FW-1:0] expq[$];
  logic [15:0]   modelCnt = '0;
  logic [P-1:0]  words[256];
  logic          monEnable = 1'b0;
  logic          prevStall = 1'b0;
  logic          prevPayHs = 1'b0;
  logic [FW-1:0] prevData = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RREADY patterns: always ready, random backpressure, or the 1,0,0 repeating stall pattern.
  always @(posedge CLK) begin
    #1;
    rrCnt++;
    case (rreadyMode)
      1:       RREADY = ($urandom_range(0, 2) != 0);
      2:       RREADY = ((rrCnt % 3) == 0);
      default: RREADY = 1'b1;
    endcase
  end

  // Compare process: outputs are sampled mid-cycle, where a handshake is already decided for the next edge.
  always @(negedge CLK) begin
    logic [FW-1:0] e;
    if (monEnable && RESETn) begin
      checkOutput("pkt_cnt", PKT_CNT, modelCnt);
      if (prevStall) begin
        checkOutput("stall_valid_hold", RVALID, 1);
        checkOutput("stall_data_hold", RDATA, prevData);
      end
      if (prevPayHs) checkOutput("flit_latency", RVALID, 1);
      if (RVALID && !RREADY) checkOutput("pay_ready_when_stalled", PAY_READY, 0);
      if (RVALID) checkOutput("busy_with_flit", BUSY, 1);
      if (RVALID && RREADY) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_flit: got %0h, expected no flit", RDATA);
        end else begin
          e = expq.pop_front();
          checkOutput("flit", RDATA, e);
          if (e[P+4]) modelCnt = modelCnt + 16'd1;
        end
      end
      prevStall = RVALID && !RREADY;
      prevData  = RDATA;
      prevPayHs = PAY_VALID && PAY_READY;
    end else begin
      prevStall = 1'b0;
      prevPayHs = 1'b0;
    end
  end

  // Issue one command, push its expected flits, then feed up to stopAfter payload words from words[].
  task automatic applyStimulus(input logic [7:0] dest, input int len, input bit gaps, input int stopAfter,
                               output int cmdCyc, output int lastCyc);
    int n;
    int i;
    bit hs;
    logic [FW-1:0] f;
    cmdCyc = 0;
    lastCyc = 0;
    CMD_DEST  = dest;
    CMD_LEN   = len[LW-1:0];
    CMD_VALID = 1'b1;
    PAY_VALID = 1'b1;
    PAY_DATA  = P'({$urandom(), $urandom()});
    n = 0;
    forever begin
      @(negedge CLK);
      hs = CMD_READY;
      if (hs) checkOutput("pay_ready_idle", PAY_READY, 0);
      @(posedge CLK);
      #1;
      if (hs) break;
      n++;
      if (n > LIMIT) begin
        checks++;
        errors++;
        $display("[TB] FAIL cmd_timeout: got no CMD_READY, expected within %0d cycles", LIMIT);
        CMD_VALID = 1'b0;
        PAY_VALID = 1'b0;
        return;
      end
    end
    cmdCyc = cyc;
    CMD_VALID = 1'b0;
    CMD_DEST  = 8'($urandom());
    CMD_LEN   = LW'($urandom());
    for (int k = 0; k <= len; k++) begin
      f = {dest, (k == 0), (k == len), 4'(k), words[k]};
      expq.push_back(f);
    end
    i = 0;
    n = 0;
    while (i <= len && i < stopAfter) begin
      PAY_DATA  = words[i];
      PAY_VALID = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge CLK);
      hs = PAY_VALID && PAY_READY;
      @(posedge CLK);
      #1;
      if (hs) begin
        i++;
        n = 0;
      end else begin
        n++;
        if (n > LIMIT) begin
          checks++;
          errors++;
          $display("[TB] FAIL pay_timeout: got %0d words accepted, expected %0d", i, len + 1);
          break;
        end
      end
    end
    lastCyc   = cyc;
    PAY_VALID = 1'b0;
    PAY_DATA  = P'({$urandom(), $urandom()});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || RVALID) && n < LIMIT) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checkOutput("drain_queue_empty", expq.size(), 0);
    checkOutput("busy_after_drain", BUSY, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c1, c2, c3, c4;
    int len;
    RESETn    = 1'b0;
    CMD_VALID = 1'b0;
    CMD_DEST  = '0;
    CMD_LEN   = '0;
    PAY_DATA  = '0;
    PAY_VALID = 1'b0;
    #23;
    checkOutput("reset_cmd_ready", CMD_READY, 1);
    checkOutput("reset_pay_ready", PAY_READY, 0);
    checkOutput("reset_rvalid", RVALID, 0);
    checkOutput("reset_rdata", RDATA, 0);
    checkOutput("reset_busy", BUSY, 0);
    checkOutput("reset_pkt_cnt", PKT_CNT, 0);
    #4;
    RESETn = 1'b1;
    monEnable = 1'b1;

    $display("[TB] basic 4-word packet");
    for (int k = 0; k < 4; k++) words[k] = P'(k + 1);
    applyStimulus(8'h5A, 3, 1'b0, 256, c1, c2);
    @(negedge CLK);
    checkOutput("last_flit_literal", RDATA, {8'h5A, 1'b0, 1'b1, 4'd3, 36'd4});
    drain();
    checkOutput("pkt_cnt_after_first", PKT_CNT, 16'd1);

    $display("[TB] single-word packet");
    words[0] = 36'hABC;
    applyStimulus(8'hC3, 0, 1'b0, 256, c1, c2);
    @(negedge CLK);
    checkOutput("single_flit_valid", RVALID, 1);
    checkOutput("single_flit_literal", RDATA, {8'hC3, 1'b1, 1'b1, 4'd0, 36'hABC});
    drain();
    checkOutput("pkt_cnt_after_single", PKT_CNT, 16'd2);

    $display("[TB] stall pattern 1,0,0");
    rreadyMode = 2;
    for (int k = 0; k < 4; k++) words[k] = P'({$urandom(), $urandom()});
    applyStimulus(8'h11, 3, 1'b0, 256, c1, c2);
    drain();

    $display("[TB] 20-word packet, sequence wrap");
    rreadyMode = 0;
    for (int k = 0; k < 20; k++) words[k] = P'({$urandom(), $urandom()});
    applyStimulus(8'h22, 19, 1'b0, 256, c1, c2);
    drain();

    $display("[TB] back-to-back two-word packets");
    for (int k = 0; k < 2; k++) words[k] = P'({$urandom(), $urandom()});
    applyStimulus(8'h33, 1, 1'b0, 256, c1, c2);
    for (int k = 0; k < 2; k++) words[k] = P'({$urandom(), $urandom()});
    applyStimulus(8'h44, 1, 1'b0, 256, c3, c4);
    checkOutput("b2b_cycles", c4 - c1, 5);
    drain();
    checkOutput("pkt_cnt_after_b2b", PKT_CNT, 16'd6);

    $display("[TB] randomized packets with backpressure");
    rreadyMode = 1;
    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(0, 40);
      for (int k = 0; k <= len; k++) words[k] = P'({$urandom(), $urandom()});
      applyStimulus(8'($urandom()), len, 1'b1, 256, c1, c2);
    end
    drain();

    $display("[TB] maximum-length packet");
    rreadyMode = 0;
    for (int k = 0; k < 256; k++) words[k] = P'({$urandom(), $urandom()});
    applyStimulus(8'h99, 255, 1'b0, 256, c1, c2);
    drain();

    $display("[TB] reset mid-packet");
    for (int k = 0; k < 5; k++) words[k] = P'({$urandom(), $urandom()});
    applyStimulus(8'h77, 4, 1'b0, 2, c1, c2);
    #2;
    RESETn = 1'b0;
    expq.delete();
    modelCnt = '0;
    #1;
    checkOutput("abort_rvalid", RVALID, 0);
    checkOutput("abort_rdata", RDATA, 0);
    checkOutput("abort_pkt_cnt", PKT_CNT, 0);
    checkOutput("abort_busy", BUSY, 0);
    checkOutput("abort_pay_ready", PAY_READY, 0);
    @(posedge CLK);
    #3;
    RESETn = 1'b1;
    #1;
    checkOutput("cmd_ready_after_reset", CMD_READY, 1);
    for (int k = 0; k < 3; k++) words[k] = P'({$urandom(), $urandom()});
    applyStimulus(8'h3C, 2, 1'b1, 256, c1, c2);
    drain();
    checkOutput("pkt_cnt_after_reset_pkt", PKT_CNT, 16'd1);

    monEnable = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
